// File: rtl/fxp_conv_pkg.sv
// Shared types and constants for the fixed-point to scaled-integer converter.
package fxp_conv_pkg;

  // Operand word layout: sign | integer bit | 8 fraction bits.
  localparam int unsigned FXP_W        = 10;
  localparam int unsigned FXP_SIGN_BIT = 9;
  localparam int unsigned FXP_FRAC_W   = 8;
  localparam int unsigned FXP_MAG_W    = FXP_W - 1;

  // Scale factor, consumed LSB-first one bit per multiply cycle.
  localparam logic [FXP_W-1:0] SCALE_CONST = 10'd1000;

  // Multiply sequencer sizing: 511 * 1000 fits in 19 bits.
  localparam int unsigned ACC_W = 19;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = 4'd9;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/fxp_mul1000_seq.sv
// Sequential shift-add multiply of a sign-magnitude operand by 1000, then >>8 with sign.
module fxp_mul1000_seq
  import fxp_conv_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [FXP_W-1:0] i_operand,
  output logic             o_done_c,
  output logic [OUT_W-1:0] o_result
);

  localparam int unsigned QUOT_W = ACC_W - FXP_FRAC_W;

  logic                 r_sign;
  logic [FXP_MAG_W-1:0] r_mag;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_active;
  logic [OUT_W-1:0]     r_result;

  logic [ACC_W-1:0]     w_addend;
  logic [ACC_W-1:0]     w_acc_next;
  logic [QUOT_W-1:0]    w_quot;
  logic [OUT_W-1:0]     w_quot_ext;
  logic [OUT_W-1:0]     w_signed;

  // Partial product for the current constant bit, and the final truncate/sign fix.
  always_comb begin
    w_addend = '0;
    if (SCALE_CONST[r_cnt]) begin
      w_addend = ACC_W'(r_mag) << r_cnt;
    end
    w_acc_next = r_acc + w_addend;
    w_quot     = w_acc_next[ACC_W-1:FXP_FRAC_W];
    w_quot_ext = OUT_W'(w_quot);
    w_signed   = r_sign ? (~w_quot_ext + OUT_W'(1)) : w_quot_ext;
  end

  assign o_done_c = r_active && (r_cnt == CNT_LAST);
  assign o_result = r_result;

  // Operand capture on start, one accumulate step per cycle, result write on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_result <= '0;
    end else if (i_start) begin
      r_sign   <= i_operand[FXP_SIGN_BIT];
      r_mag    <= i_operand[FXP_MAG_W-1:0];
      r_acc    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_acc <= w_acc_next;
      if (o_done_c) begin
        r_result <= w_signed;
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fxp_conv_arbiter.sv
// Round-robin arbiter sharing one fixed-point x1000 converter among NREQ requesters.
module fxp_conv_arbiter
  import fxp_conv_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*FXP_W-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUT_W-1:0]        res_data,
  output logic [$clog2(NREQ)-1:0] res_tag,
  output logic                    busy
);

  localparam int unsigned TAG_W = $clog2(NREQ);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NREQ - 1);

  conv_state_e      r_state;
  logic [TAG_W-1:0] r_ptr;
  logic [TAG_W-1:0] r_tag;
  logic             r_res_valid;

  logic             w_any;
  int unsigned      w_idx;
  logic [TAG_W-1:0] w_grant_idx;
  logic [TAG_W-1:0] w_ptr_next;
  logic [FXP_W-1:0] w_operand;
  logic             w_start;
  logic             w_done;

  // First valid requester searching upward from the priority pointer, with wrap.
  always_comb begin
    w_any       = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!w_any && req_valid[TAG_W'(w_idx)]) begin
        w_any       = 1'b1;
        w_grant_idx = TAG_W'(w_idx);
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    w_ptr_next = (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + TAG_W'(1);
  end

  // Select the winning requester's operand word.
  always_comb begin
    w_operand = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant_idx == TAG_W'(i)) begin
        w_operand = req_data[i*FXP_W +: FXP_W];
      end
    end
  end

  // Accept pulse only in IDLE; held low throughout reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == IDLE) && w_any) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_start = (r_state == IDLE) && w_any;

  fxp_mul1000_seq #(
    .OUT_W (OUT_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_operand (w_operand),
    .o_done_c  (w_done),
    .o_result  (res_data)
  );

  // Controller FSM: grant and tag capture, multiply wait, result hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_tag       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_tag   <= w_grant_idx;
            r_ptr   <= w_ptr_next;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (w_done) begin
            r_res_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_tag   = r_tag;
  assign busy      = (r_state != IDLE);

endmodule
